// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared SRAM word width, arbiter defaults, FSM states and pointer helper
package sram_port_arbiter_pkg;
  localparam int SRAM_WORD = 256;
  localparam int NUM_REQ_DEF = 4;
  localparam int RD_LAT_DEF = 3;
  typedef enum logic {IDLE, RD_WAIT} arb_state_e;
  function automatic int wrap_inc(input int k, input int n);
    return (k + 1) % n;
  endfunction
endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// sram_port_arbiter_rr_pick: round-robin picker returning one-hot grant, index and any-request flag
module sram_port_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] cand [N];
  // scan candidates in rotated order starting at the pointer; the first requester wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand[i] = IW'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[cand[i]]) begin
        gnt_o[cand[i]] = 1'b1;
        idx_o = cand[i];
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin read/write arbiter of PE groups onto one SRAM controller port
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WORD = SRAM_WORD,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [NUM_REQ-1:0]      i_send,
  input  logic [NUM_REQ*WORD-1:0] i_send_data,
  output logic [NUM_REQ-1:0]      o_rd_valid,
  output logic [WORD-1:0]         o_rd_data,
  output logic [NUM_REQ-1:0]      o_send_ack,
  output logic                    o_PE_request,
  output logic                    o_PE_send,
  output logic [WORD-1:0]         o_send_data,
  input  logic [WORD-1:0]         i_request_data,
  input  logic                    i_busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int LW = $clog2(RD_LAT + 1);
  arb_state_e state_q, state_d;
  logic [IW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [WORD-1:0] cap_q, cap_d;
  logic [NUM_REQ-1:0] rd_valid_q, send_ack_q;
  logic [WORD-1:0] rd_data_q, send_data_q;
  logic pe_req_q, pe_send_q;
  logic [NUM_REQ-1:0] wr_pend, rd_pend, wr_gnt, rd_gnt;
  logic [IW-1:0] wr_idx, rd_idx;
  logic wr_any, rd_any, ret, wr_go, rd_go;

  // lat_cnt of zero while waiting marks the return cycle: captured word goes out next edge
  assign ret = state_q == RD_WAIT && lat_q == '0;
  // a request whose handshake pulse is on the bus this cycle is already served
  assign wr_pend = i_send & ~send_ack_q;
  assign rd_pend = i_req & ~rd_valid_q & ~({NUM_REQ{state_q == RD_WAIT}} & owner_q);
  assign wr_go = wr_any && !i_busy;
  assign rd_go = rd_any && !wr_any && !i_busy && (state_q == IDLE || ret);

  sram_port_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_wr_pick (
    .req_i(wr_pend), .ptr_i(wr_ptr_q), .gnt_o(wr_gnt), .idx_o(wr_idx), .any_o(wr_any)
  );
  sram_port_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_rd_pick (
    .req_i(rd_pend), .ptr_i(rd_ptr_q), .gnt_o(rd_gnt), .idx_o(rd_idx), .any_o(rd_any)
  );

  // next state: pointer advance on grants, read latency count, capture and return
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    owner_d = owner_q;
    lat_d = lat_q;
    cap_d = cap_q;
    if (wr_go) wr_ptr_d = IW'(wrap_inc(int'(wr_idx), NUM_REQ));
    if (state_q == RD_WAIT) begin
      if (lat_q == LW'(RD_LAT)) begin
        cap_d = i_request_data;
        lat_d = '0;
      end else if (lat_q != '0) lat_d = lat_q + 1'b1;
      else state_d = IDLE;
    end
    if (rd_go) begin
      state_d = RD_WAIT;
      owner_d = rd_gnt;
      rd_ptr_d = IW'(wrap_inc(int'(rd_idx), NUM_REQ));
      lat_d = LW'(1);
    end
  end

  // control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      owner_q <= '0;
      lat_q <= '0;
      cap_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      owner_q <= owner_d;
      lat_q <= lat_d;
      cap_q <= cap_d;
    end
  end

  // registered outputs: single-cycle strobes and handshakes, data buses zero when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_send_q <= 1'b0;
      send_ack_q <= '0;
      send_data_q <= '0;
      pe_req_q <= 1'b0;
      rd_valid_q <= '0;
      rd_data_q <= '0;
    end else begin
      pe_send_q <= wr_go;
      send_ack_q <= wr_go ? wr_gnt : '0;
      send_data_q <= wr_go ? i_send_data[int'(wr_idx)*WORD +: WORD] : '0;
      pe_req_q <= rd_go;
      rd_valid_q <= ret ? owner_q : '0;
      rd_data_q <= ret ? cap_q : '0;
    end
  end

  assign o_PE_send = pe_send_q;
  assign o_send_ack = send_ack_q;
  assign o_send_data = send_data_q;
  assign o_PE_request = pe_req_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data = rd_data_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scenario tasks with a scoreboard of expected read returns and write acks
module tb_sram_port_arbiter;
  localparam int N = 4;
  localparam int W = 256;
  localparam int RD_LAT = 3;
  typedef struct {
    int cyc;
    logic [N-1:0] v;
    logic [W-1:0] d;
  } ev_t;

  logic clk, rst_n, i_busy, o_PE_request, o_PE_send;
  logic [N-1:0] i_req, i_send, o_rd_valid, o_send_ack;
  logic [N*W-1:0] i_send_data;
  logic [W-1:0] o_rd_data, o_send_data, i_request_data;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  ev_t rd_q[$];
  ev_t wr_q[$];
  ev_t grant_q[$];
  ev_t em, ew;

  sram_port_arbiter #(.NUM_REQ(N), .WORD(W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_send(i_send), .i_send_data(i_send_data),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_send_ack(o_send_ack),
    .o_PE_request(o_PE_request), .o_PE_send(o_PE_send), .o_send_data(o_send_data),
    .i_request_data(i_request_data), .i_busy(i_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // scoreboard: pop expected returns/acks as the DUT produces them
  always @(negedge clk) begin
    if (rst_n) begin
      n_chk++;
      if (o_PE_request && o_PE_send) begin
        n_fail++;
        $display("FAIL both_strobes: req=%b send=%b at cycle %0d, required never both high", o_PE_request, o_PE_send, cyc);
      end
      n_chk++;
      if (o_rd_valid != '0) begin
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: rd_valid=%b at cycle %0d, required no return", o_rd_valid, cyc);
        end else begin
          em = rd_q.pop_front();
          if (o_rd_valid !== em.v || o_rd_data !== em.d || cyc != em.cyc) begin
            n_fail++;
            $display("FAIL rd_return: valid=%b cyc=%0d data=%h, required valid=%b cyc=%0d data=%h", o_rd_valid, cyc, o_rd_data, em.v, em.cyc, em.d);
          end
        end
      end else if (o_rd_data !== '0) begin
        n_fail++;
        $display("FAIL rd_data_idle: data=%h, required 0", o_rd_data);
      end
      n_chk++;
      if (o_send_ack != '0 || o_PE_send) begin
        if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: ack=%b send=%b at cycle %0d, required no write", o_send_ack, o_PE_send, cyc);
        end else begin
          ew = wr_q.pop_front();
          if (o_send_ack !== ew.v || o_PE_send !== 1'b1 || o_send_data !== ew.d || cyc != ew.cyc) begin
            n_fail++;
            $display("FAIL wr_issue: ack=%b send=%b cyc=%0d data=%h, required ack=%b send=1 cyc=%0d data=%h", o_send_ack, o_PE_send, cyc, o_send_data, ew.v, ew.cyc, ew.d);
          end
        end
      end else if (o_send_data !== '0) begin
        n_fail++;
        $display("FAIL wr_data_idle: data=%h, required 0", o_send_data);
      end
    end
  end

  // advance one cycle acting as requesters and SRAM controller
  task automatic step();
    @(posedge clk);
    #1;
    i_req = i_req & ~o_rd_valid;
    i_send = i_send & ~o_send_ack;
    if (o_PE_request && grant_q.size() > 0) begin
      ev_t g;
      g = grant_q.pop_front();
      i_request_data = g.d;
      rd_q.push_back(ev_t'{cyc + RD_LAT + 1, g.v, g.d});
    end
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (i_req == '0 && i_send == '0 && rd_q.size() == 0 && wr_q.size() == 0 && grant_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (o_PE_request !== 1'b0) begin n_fail++; $display("FAIL reset_pe_request: %b, required 0", o_PE_request); end
    n_chk++;
    if (o_PE_send !== 1'b0) begin n_fail++; $display("FAIL reset_pe_send: %b, required 0", o_PE_send); end
    n_chk++;
    if (o_rd_valid !== '0 || o_send_ack !== '0) begin n_fail++; $display("FAIL reset_pulses: rd_valid=%b ack=%b, required 0", o_rd_valid, o_send_ack); end
    n_chk++;
    if (o_rd_data !== '0 || o_send_data !== '0) begin n_fail++; $display("FAIL reset_data: rd=%h wr=%h, required 0", o_rd_data, o_send_data); end
    rst_n = 1'b1;
    step();
    n_chk++;
    if (o_PE_request !== 1'b0 || o_PE_send !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: req=%b send=%b, required 0", o_PE_request, o_PE_send); end
  endtask

  task automatic test_read_rr();
    bit ok;
    grant_q.push_back(ev_t'{0, 4'b0010, {32{8'hA5}}});
    grant_q.push_back(ev_t'{0, 4'b0100, {32{8'h5A}}});
    i_req = 4'b0110;
    step();
    n_chk++;
    if (o_PE_request !== 1'b1) begin n_fail++; $display("FAIL rd_first_strobe: %b, required 1", o_PE_request); end
    repeat (RD_LAT + 1) step();
    n_chk++;
    if (o_rd_valid !== 4'b0010 || o_PE_request !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_regrant: rd_valid=%b req=%b, required 0010 and 1", o_rd_valid, o_PE_request);
    end
    drain(40, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL rd_rr_timeout: done=%b, required 1", ok); end
  endtask

  task automatic test_write_rr();
    bit ok;
    logic [W-1:0] s;
    for (int k = 0; k < N; k++) begin
      s = {8{32'hC0DE_0000 + 32'(k)}};
      i_send_data[k*W +: W] = s;
      wr_q.push_back(ev_t'{cyc + 1 + k, 4'b0001 << k, s});
    end
    i_send = 4'b1111;
    drain(40, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL wr_rr_timeout: done=%b, required 1", ok); end
  endtask

  task automatic test_priority();
    bit ok;
    logic [W-1:0] s;
    s = {8{32'hBEEF_0002}};
    i_send_data[2*W +: W] = s;
    wr_q.push_back(ev_t'{cyc + 1, 4'b0100, s});
    grant_q.push_back(ev_t'{0, 4'b0001, {32{8'h3C}}});
    i_req = 4'b0001;
    i_send = 4'b0100;
    step();
    n_chk++;
    if (o_PE_send !== 1'b1 || o_PE_request !== 1'b0) begin n_fail++; $display("FAIL prio_write_first: send=%b req=%b, required 1 and 0", o_PE_send, o_PE_request); end
    step();
    n_chk++;
    if (o_PE_request !== 1'b1 || o_PE_send !== 1'b0) begin n_fail++; $display("FAIL prio_read_next: req=%b send=%b, required 1 and 0", o_PE_request, o_PE_send); end
    drain(40, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL prio_timeout: done=%b, required 1", ok); end
  endtask

  task automatic test_busy();
    bit ok;
    grant_q.push_back(ev_t'{0, 4'b0001, {32{8'h69}}});
    i_busy = 1'b1;
    i_req = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      n_chk++;
      if (o_PE_request !== 1'b0 || o_PE_send !== 1'b0) begin n_fail++; $display("FAIL busy_no_strobe: req=%b send=%b cycle %0d, required 0", o_PE_request, o_PE_send, k); end
    end
    i_busy = 1'b0;
    step();
    n_chk++;
    if (o_PE_request !== 1'b1) begin n_fail++; $display("FAIL busy_release_strobe: %b, required 1", o_PE_request); end
    drain(40, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL busy_timeout: done=%b, required 1", ok); end
  endtask

  task automatic test_write_during_read();
    bit ok;
    logic [W-1:0] s0, s3;
    grant_q.push_back(ev_t'{0, 4'b0010, {16{16'hD00D}}});
    i_req = 4'b0010;
    step();
    n_chk++;
    if (o_PE_request !== 1'b1) begin n_fail++; $display("FAIL wdr_strobe: %b, required 1", o_PE_request); end
    s0 = {8{32'h1111_0000}};
    s3 = {8{32'h3333_0003}};
    i_send_data[0 +: W] = s0;
    i_send_data[3*W +: W] = s3;
    wr_q.push_back(ev_t'{cyc + 1, 4'b1000, s3});
    wr_q.push_back(ev_t'{cyc + 2, 4'b0001, s0});
    i_send = 4'b1001;
    drain(40, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL wdr_timeout: done=%b, required 1", ok); end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    logic [W-1:0] s0, s3;
    grant_q.push_back(ev_t'{0, 4'b0100, {32{8'hEE}}});
    i_req = 4'b0100;
    step();
    n_chk++;
    if (o_PE_request !== 1'b1) begin n_fail++; $display("FAIL rmr_strobe: %b, required 1", o_PE_request); end
    step();
    i_req = '0;
    rst_n = 1'b0;
    #2;
    n_chk++;
    if (o_PE_request !== 1'b0 || o_PE_send !== 1'b0 || o_rd_valid !== '0 || o_send_ack !== '0 || o_rd_data !== '0 || o_send_data !== '0) begin
      n_fail++;
      $display("FAIL rmr_outputs: req=%b send=%b rv=%b ack=%b, required all 0", o_PE_request, o_PE_send, o_rd_valid, o_send_ack);
    end
    rd_q.delete();
    grant_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_chk++;
      if (o_rd_valid !== '0) begin n_fail++; $display("FAIL rmr_no_return: rd_valid=%b, required 0", o_rd_valid); end
    end
    s0 = {8{32'hAAAA_0000}};
    s3 = {8{32'hAAAA_0003}};
    i_send_data[0 +: W] = s0;
    i_send_data[3*W +: W] = s3;
    wr_q.push_back(ev_t'{cyc + 1, 4'b0001, s0});
    wr_q.push_back(ev_t'{cyc + 2, 4'b1000, s3});
    grant_q.push_back(ev_t'{0, 4'b0001, {32{8'h77}}});
    grant_q.push_back(ev_t'{0, 4'b1000, {32{8'h88}}});
    i_send = 4'b1001;
    i_req = 4'b1001;
    repeat (3) step();
    n_chk++;
    if (o_PE_request !== 1'b1) begin n_fail++; $display("FAIL rmr_read_after_writes: %b, required 1", o_PE_request); end
    drain(40, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL rmr_timeout: done=%b, required 1", ok); end
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = '0;
    i_send = '0;
    i_send_data = '0;
    i_request_data = '0;
    i_busy = 1'b0;
    test_reset();
    test_read_rr();
    test_write_rr();
    test_priority();
    test_busy();
    test_write_during_read();
    test_reset_mid_read();
    repeat (3) step();
    n_chk++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin n_fail++; $display("FAIL leftover: rd=%0d wr=%0d, required 0", rd_q.size(), wr_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of PE-group requesters, 2..8.
REQ-002 Parameter WORD, default 256: SRAM word width; equals shared Sram_Word.
REQ-003 Parameter RD_LAT, default 3: cycles from o_PE_request high to valid i_request_data.
REQ-004 clk  input  1  clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 i_req  input  NUM_REQ  per-requester read request; level, held until o_rd_valid of that bit.
REQ-007 i_send  input  NUM_REQ  per-requester write request; level, held until o_send_ack of that bit.
REQ-008 i_send_data  input  NUM_REQ*WORD  write words; slice k belongs to requester k.
REQ-009 o_rd_valid  output  NUM_REQ  one-cycle pulse; read data for that requester on o_rd_data.
REQ-010 o_rd_data  output  WORD  read word; zero when no o_rd_valid bit is high.
REQ-011 o_send_ack  output  NUM_REQ  one-cycle pulse; that requester's write was issued.
REQ-012 o_PE_request  output  1  read strobe to SRAM controller.
REQ-013 o_PE_send  output  1  write strobe to SRAM controller.
REQ-014 o_send_data  output  WORD  write word to SRAM controller; zero when o_PE_send low.
REQ-015 i_request_data  input  WORD  read word returned by SRAM controller.
REQ-016 i_busy  input  1  SRAM controller busy (init / T load); no strobes issued while high.

Function
REQ-017 All outputs registered; strobes and acks pulse for exactly one cycle.
REQ-018 FSM states: IDLE (no read outstanding), RD_WAIT (read outstanding); reset state IDLE.
REQ-019 o_PE_request and o_PE_send are never high in the same cycle.
REQ-020 Writes take priority over reads in any cycle both are pending.
REQ-021 Write grant: round-robin over i_send starting at wr_ptr; grant k drives o_PE_send=1, o_send_data=slice k, o_send_ack[k]=1 in the same cycle; wr_ptr <= (k+1) mod NUM_REQ.
REQ-022 Writes may issue in IDLE or RD_WAIT; back-to-back writes allowed every cycle.
REQ-023 Read grant only in IDLE with no write pending: round-robin over i_req at rd_ptr; grant k drives o_PE_request=1, records owner k, rd_ptr <= (k+1) mod NUM_REQ, state <= RD_WAIT, lat_cnt <= 1.
REQ-024 In RD_WAIT lat_cnt increments each cycle; when lat_cnt==RD_LAT, i_request_data is captured, next cycle o_rd_valid[owner]=1 with o_rd_data=captured word, state <= IDLE.
REQ-025 Maximum one outstanding read; i_req bits ignored until the return cycle; a new read may issue in the cycle o_rd_valid is high.
REQ-026 Read request of the owner is not re-granted before its o_rd_valid.
REQ-027 While i_busy=1 no new strobes issue and pointers hold; an outstanding read still completes per REQ-024.
REQ-028 Same requester with i_req and i_send both high: write served first, read later.
REQ-029 Pointers wrap NUM_REQ-1 -> 0; lat_cnt width clog2(RD_LAT+1).

Reset
REQ-030 On rst_n low: state IDLE, wr_ptr=0, rd_ptr=0, lat_cnt=0, owner=0, all outputs 0.
REQ-031 Reset mid-read discards the outstanding read; no o_rd_valid after release.

Structure
REQ-032 WORD, RD_LAT default and NUM_REQ default are defined in the shared util defines beside Sram_Word.
REQ-033 One sub-module rr_pick (round-robin priority picker: request vector, pointer -> one-hot grant, index, any) instantiated twice (read, write).

Verification
REQ-034 i_req=4'b0110, RD_LAT=3, i_request_data=0xA5.. returned -> o_PE_request at t0, o_rd_valid=4'b0010 at t0+4 with 0xA5..; then 4'b0100 granted.
REQ-035 i_send=4'b1111 held, all acked -> o_send_ack order 0,1,2,3, one per cycle, o_send_data matching slices.
REQ-036 i_req[0] and i_send[2] same cycle -> write to 2 first, read of 0 next cycle; never both strobes.
REQ-037 i_busy=1 for 10 cycles with i_req=4'b0001 -> no strobe; o_PE_request the cycle after i_busy falls.
REQ-038 Sends during RD_WAIT -> writes issue, read data still delivered at t0+RD_LAT+1.
REQ-039 rst_n pulsed in RD_WAIT -> all outputs 0, no o_rd_valid after release, pointers 0.
